// File: rtl/cpu_pipe_pkg.sv
// Shared encodings for the 5-stage core's pipeline sequencing and hazard control.
package cpu_pipe_pkg;

  localparam int DEF_REG_AW = 4;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_STOP  = 2'd2
  } halt_state_e;

endpackage

// File: rtl/fwd_select.sv
// EX operand bypass select for one source operand; MEM result wins over WB.
module fwd_select
  import cpu_pipe_pkg::*;
#(
  parameter int REG_AW   = DEF_REG_AW,
  parameter int ZERO_REG = 1
) (
  input  logic [REG_AW-1:0] src,
  input  logic              use_src,
  input  logic              mem_valid,
  input  logic              mem_rw,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_valid,
  input  logic              wb_rw,
  input  logic [REG_AW-1:0] wb_rd,
  output logic [1:0]        sel
);

  localparam logic              ZR = (ZERO_REG != 0);
  localparam logic [REG_AW-1:0] RZ = '0;

  logic mem_hit_s;
  logic wb_hit_s;

  // A stage supplies the operand only if it really writes the register being read
  assign mem_hit_s = mem_valid & mem_rw & use_src & (mem_rd == src) & ~(ZR & (mem_rd == RZ));
  assign wb_hit_s  = wb_valid  & wb_rw  & use_src & (wb_rd  == src) & ~(ZR & (wb_rd  == RZ));

  // Priority encode the two bypass sources
  always_comb begin
    sel = FWD_REG;
    if (mem_hit_s) begin
      sel = FWD_MEM;
    end else if (wb_hit_s) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_REG;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing and hazard control: stage shadows, stalls, bubbles,
// flushes, multi-cycle EX hold and the drain-then-stop halt sequence.
module pipe_hazard_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int REG_AW   = DEF_REG_AW,
  parameter int EX_LAT   = 3,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_multi,
  input  logic              id_halt,
  input  logic              br_taken,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              ex_hold,
  output logic              mem_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              halted,
  output logic [2:0]        stage_valid
);

  localparam logic              ZR      = (ZERO_REG != 0);
  localparam logic [REG_AW-1:0] RZ      = '0;
  localparam logic [3:0]        EX_LOAD = 4'(EX_LAT - 1);

  logic              ex_valid_r, ex_use1_r, ex_use2_r, ex_rw_r, ex_mr_r, ex_multi_r;
  logic [REG_AW-1:0] ex_rs1_r, ex_rs2_r, ex_rd_r;
  logic              mem_valid_r, mem_rw_r, wb_valid_r, wb_rw_r;
  logic [REG_AW-1:0] mem_rd_r, wb_rd_r;
  logic [3:0]        ex_cnt_r;
  halt_state_e       state_r;

  logic hold_s, lu_s, halt_go_s, ex_load_s;

  // Hazard detection from registered EX state and the instruction sitting in ID
  always_comb begin
    hold_s = ex_valid_r & ex_multi_r & (ex_cnt_r != 4'd0);
    lu_s   = 1'b0;
    if (ex_valid_r && ex_mr_r && !(ZR && (ex_rd_r == RZ))) begin
      lu_s = (id_use_rs1 & (id_rs1 == ex_rd_r)) | (id_use_rs2 & (id_rs2 == ex_rd_r));
    end else begin
      lu_s = 1'b0;
    end
    halt_go_s = (state_r == ST_RUN) & id_valid & id_halt & ~br_taken & ~hold_s & ~lu_s;
  end

  // Enable/bubble generation; branch beats hold beats load-use beats halt drain
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    ex_hold     = 1'b0;
    mem_bubble  = 1'b0;
    ex_load_s   = 1'b0;
    if (state_r == ST_STOP) begin
      ex_load_s = 1'b0;
    end else if ((state_r == ST_RUN) && br_taken) begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (hold_s) begin
      ex_hold    = 1'b1;
      mem_bubble = 1'b1;
    end else if (lu_s || halt_go_s || (state_r == ST_DRAIN)) begin
      // The accepted halt never occupies EX, so only older work has to drain
      idex_bubble = 1'b1;
    end else begin
      pc_en     = 1'b1;
      ifid_en   = 1'b1;
      ex_load_s = 1'b1;
    end
  end

  // Shadow pipeline and multi-cycle EX counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_valid_r  <= 1'b0;
      ex_rs1_r    <= RZ;
      ex_rs2_r    <= RZ;
      ex_use1_r   <= 1'b0;
      ex_use2_r   <= 1'b0;
      ex_rd_r     <= RZ;
      ex_rw_r     <= 1'b0;
      ex_mr_r     <= 1'b0;
      ex_multi_r  <= 1'b0;
      ex_cnt_r    <= 4'd0;
      mem_valid_r <= 1'b0;
      mem_rd_r    <= RZ;
      mem_rw_r    <= 1'b0;
      wb_valid_r  <= 1'b0;
      wb_rd_r     <= RZ;
      wb_rw_r     <= 1'b0;
    end else begin
      wb_valid_r <= mem_valid_r;
      wb_rd_r    <= mem_rd_r;
      wb_rw_r    <= mem_rw_r;
      if (hold_s) begin
        ex_cnt_r    <= ex_cnt_r - 4'd1;
        mem_valid_r <= 1'b0;
      end else begin
        mem_valid_r <= ex_valid_r;
        mem_rd_r    <= ex_rd_r;
        mem_rw_r    <= ex_rw_r;
        if (ex_load_s) begin
          ex_valid_r <= id_valid;
          ex_rs1_r   <= id_rs1;
          ex_rs2_r   <= id_rs2;
          ex_use1_r  <= id_use_rs1;
          ex_use2_r  <= id_use_rs2;
          ex_rd_r    <= id_rd;
          ex_rw_r    <= id_reg_write;
          ex_mr_r    <= id_mem_read;
          ex_multi_r <= id_multi;
          ex_cnt_r   <= (id_valid && id_multi) ? EX_LOAD : 4'd0;
        end else begin
          ex_valid_r <= 1'b0;
          ex_cnt_r   <= 4'd0;
        end
      end
    end
  end

  // Halt sequencer: stop only once every older instruction has left WB
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_RUN;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (halt_go_s) begin
            state_r <= ST_DRAIN;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (!ex_valid_r && !mem_valid_r && !wb_valid_r) begin
            state_r <= ST_STOP;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        ST_STOP: state_r <= ST_STOP;
        default: state_r <= ST_RUN;
      endcase
    end
  end

  assign halted      = (state_r == ST_STOP);
  assign stage_valid = {wb_valid_r, mem_valid_r, ex_valid_r};

  fwd_select #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_fwd_a (
    .src(ex_rs1_r), .use_src(ex_use1_r),
    .mem_valid(mem_valid_r), .mem_rw(mem_rw_r), .mem_rd(mem_rd_r),
    .wb_valid(wb_valid_r), .wb_rw(wb_rw_r), .wb_rd(wb_rd_r),
    .sel(fwd_a)
  );

  fwd_select #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_fwd_b (
    .src(ex_rs2_r), .use_src(ex_use2_r),
    .mem_valid(mem_valid_r), .mem_rw(mem_rw_r), .mem_rd(mem_rd_r),
    .wb_valid(wb_valid_r), .wb_rw(wb_rw_r), .wb_rd(wb_rd_r),
    .sel(fwd_b)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (REG_AW=4, EX_LAT=3, ZERO_REG=1).
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic       v;
    logic [3:0] rs1;
    logic       u1;
    logic [3:0] rs2;
    logic       u2;
    logic [3:0] rd;
    logic       rw;
    logic       mr;
    logic       mul;
    logic       hlt;
    logic       br;
  } stim_t;

  logic       clk, rst;
  logic       id_valid, id_use_rs1, id_use_rs2;
  logic [3:0] id_rs1, id_rs2, id_rd;
  logic       id_reg_write, id_mem_read, id_multi, id_halt, br_taken;
  logic       pc_en, ifid_en, ifid_flush, idex_bubble, ex_hold, mem_bubble, halted;
  logic [1:0] fwd_a, fwd_b;
  logic [2:0] stage_valid;

  logic [13:0] exp_q[$];
  int compared = 0;
  int failed   = 0;

  pipe_hazard_ctrl #(.REG_AW(4), .EX_LAT(3), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_multi(id_multi), .id_halt(id_halt), .br_taken(br_taken),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .ex_hold(ex_hold), .mem_bubble(mem_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted), .stage_valid(stage_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus builders
  function automatic stim_t nop_i();
    stim_t s;
    s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  function automatic stim_t alu_i(input int rd);
    stim_t s;
    s = nop_i();
    s.v  = 1'b1;
    s.rd = 4'(rd);
    s.rw = 1'b1;
    return s;
  endfunction

  function automatic stim_t use_i(input int rs1, input int u1, input int rs2, input int u2, input int rd);
    stim_t s;
    s = alu_i(rd);
    s.rs1 = 4'(rs1);
    s.u1  = 1'(u1);
    s.rs2 = 4'(rs2);
    s.u2  = 1'(u2);
    return s;
  endfunction

  function automatic stim_t ld_i(input int rd);
    stim_t s;
    s = alu_i(rd);
    s.mr = 1'b1;
    return s;
  endfunction

  function automatic stim_t mul_i(input int rd);
    stim_t s;
    s = alu_i(rd);
    s.mul = 1'b1;
    return s;
  endfunction

  function automatic stim_t halt_i();
    stim_t s;
    s = nop_i();
    s.v   = 1'b1;
    s.hlt = 1'b1;
    return s;
  endfunction

  function automatic stim_t br_i(input stim_t x);
    stim_t s;
    s = x;
    s.br = 1'b1;
    return s;
  endfunction

  function automatic stim_t rst_i(input stim_t x);
    stim_t s;
    s = x;
    s.rst = 1'b0;
    return s;
  endfunction

  // Expected output vector {pc,ifid,flush,bubble,hold,mem_bubble,fwd_a,fwd_b,halted,stage_valid}
  function automatic logic [13:0] exp_v(input int pc, input int ie, input int fl, input int bb,
                                        input int hd, input int mb, input int fa, input int fb,
                                        input int h, input int sv);
    return {1'(pc), 1'(ie), 1'(fl), 1'(bb), 1'(hd), 1'(mb), 2'(fa), 2'(fb), 1'(h), 3'(sv)};
  endfunction

  function automatic logic [13:0] nrm(input int fa, input int fb, input int sv);
    return exp_v(1, 1, 0, 0, 0, 0, fa, fb, 0, sv);
  endfunction

  task automatic apply(input stim_t s);
    rst          = s.rst;
    id_valid     = s.v;
    id_rs1       = s.rs1;
    id_use_rs1   = s.u1;
    id_rs2       = s.rs2;
    id_use_rs2   = s.u2;
    id_rd        = s.rd;
    id_reg_write = s.rw;
    id_mem_read  = s.mr;
    id_multi     = s.mul;
    id_halt      = s.hlt;
    br_taken     = s.br;
  endtask

  task automatic test_reset();
    stim_t st[2];
    logic [13:0] ex[2];
    logic [13:0] got, e;
    st = '{rst_i(nop_i()), nop_i()};
    ex = '{nrm(0, 0, 'b000), nrm(0, 0, 'b000)};
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      apply(st[i]);
      exp_q.push_back(ex[i]);
      #3;
      got = {pc_en, ifid_en, ifid_flush, idex_bubble, ex_hold, mem_bubble, fwd_a, fwd_b, halted, stage_valid};
      e = exp_q.pop_front();
      compared++;
      if (got !== e) begin
        failed++;
        $display("FAIL reset[%0d]: got %b required %b", i, got, e);
      end
    end
  endtask

  task automatic test_forwarding();
    stim_t st[9];
    logic [13:0] ex[9];
    logic [13:0] got, e;
    st = '{alu_i(3), alu_i(3), use_i(3, 1, 3, 0, 0), use_i(3, 0, 3, 1, 7), use_i(0, 1, 0, 0, 10),
           nop_i(), nop_i(), nop_i(), nop_i()};
    ex = '{nrm(0, 0, 'b000), nrm(0, 0, 'b001), nrm(0, 0, 'b011), nrm(1, 0, 'b111), nrm(0, 2, 'b111),
           nrm(0, 0, 'b111), nrm(0, 0, 'b110), nrm(0, 0, 'b100), nrm(0, 0, 'b000)};
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      apply(st[i]);
      exp_q.push_back(ex[i]);
      #3;
      got = {pc_en, ifid_en, ifid_flush, idex_bubble, ex_hold, mem_bubble, fwd_a, fwd_b, halted, stage_valid};
      e = exp_q.pop_front();
      compared++;
      if (got !== e) begin
        failed++;
        $display("FAIL forwarding[%0d]: got %b required %b", i, got, e);
      end
    end
  endtask

  task automatic test_load_use();
    stim_t st[10];
    logic [13:0] ex[10];
    logic [13:0] got, e;
    st = '{ld_i(5), use_i(5, 1, 0, 0, 6), use_i(5, 1, 0, 0, 6), nop_i(), ld_i(0),
           use_i(0, 1, 0, 0, 11), nop_i(), nop_i(), nop_i(), nop_i()};
    ex = '{nrm(0, 0, 'b000), exp_v(0, 0, 0, 1, 0, 0, 0, 0, 0, 'b001), nrm(0, 0, 'b010),
           nrm(2, 0, 'b101), nrm(0, 0, 'b010), nrm(0, 0, 'b101), nrm(0, 0, 'b011),
           nrm(0, 0, 'b110), nrm(0, 0, 'b100), nrm(0, 0, 'b000)};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      apply(st[i]);
      exp_q.push_back(ex[i]);
      #3;
      got = {pc_en, ifid_en, ifid_flush, idex_bubble, ex_hold, mem_bubble, fwd_a, fwd_b, halted, stage_valid};
      e = exp_q.pop_front();
      compared++;
      if (got !== e) begin
        failed++;
        $display("FAIL load_use[%0d]: got %b required %b", i, got, e);
      end
    end
  endtask

  task automatic test_multi_cycle();
    stim_t st[8];
    logic [13:0] ex[8];
    logic [13:0] got, e;
    st = '{mul_i(2), use_i(2, 1, 0, 0, 8), use_i(2, 1, 0, 0, 8), use_i(2, 1, 0, 0, 8),
           nop_i(), nop_i(), nop_i(), nop_i()};
    ex = '{nrm(0, 0, 'b000), exp_v(0, 0, 0, 0, 1, 1, 0, 0, 0, 'b001),
           exp_v(0, 0, 0, 0, 1, 1, 0, 0, 0, 'b001), nrm(0, 0, 'b001), nrm(1, 0, 'b011),
           nrm(0, 0, 'b110), nrm(0, 0, 'b100), nrm(0, 0, 'b000)};
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      apply(st[i]);
      exp_q.push_back(ex[i]);
      #3;
      got = {pc_en, ifid_en, ifid_flush, idex_bubble, ex_hold, mem_bubble, fwd_a, fwd_b, halted, stage_valid};
      e = exp_q.pop_front();
      compared++;
      if (got !== e) begin
        failed++;
        $display("FAIL multi_cycle[%0d]: got %b required %b", i, got, e);
      end
    end
  endtask

  task automatic test_branch_over_load_use();
    stim_t st[5];
    logic [13:0] ex[5];
    logic [13:0] got, e;
    st = '{ld_i(5), br_i(use_i(5, 1, 0, 0, 6)), nop_i(), nop_i(), nop_i()};
    ex = '{nrm(0, 0, 'b000), exp_v(1, 1, 1, 1, 0, 0, 0, 0, 0, 'b001), nrm(0, 0, 'b010),
           nrm(0, 0, 'b100), nrm(0, 0, 'b000)};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      apply(st[i]);
      exp_q.push_back(ex[i]);
      #3;
      got = {pc_en, ifid_en, ifid_flush, idex_bubble, ex_hold, mem_bubble, fwd_a, fwd_b, halted, stage_valid};
      e = exp_q.pop_front();
      compared++;
      if (got !== e) begin
        failed++;
        $display("FAIL branch[%0d]: got %b required %b", i, got, e);
      end
    end
  endtask

  task automatic test_halt_drain();
    stim_t st[9];
    logic [13:0] ex[9];
    logic [13:0] got, e;
    st = '{alu_i(1), alu_i(2), alu_i(9), halt_i(), halt_i(), halt_i(), halt_i(), halt_i(), nop_i()};
    ex = '{nrm(0, 0, 'b000), nrm(0, 0, 'b001), nrm(0, 0, 'b011),
           exp_v(0, 0, 0, 1, 0, 0, 0, 0, 0, 'b111), exp_v(0, 0, 0, 1, 0, 0, 0, 0, 0, 'b110),
           exp_v(0, 0, 0, 1, 0, 0, 0, 0, 0, 'b100), exp_v(0, 0, 0, 1, 0, 0, 0, 0, 0, 'b000),
           exp_v(0, 0, 0, 0, 0, 0, 0, 0, 1, 'b000), exp_v(0, 0, 0, 0, 0, 0, 0, 0, 1, 'b000)};
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      apply(st[i]);
      exp_q.push_back(ex[i]);
      #3;
      got = {pc_en, ifid_en, ifid_flush, idex_bubble, ex_hold, mem_bubble, fwd_a, fwd_b, halted, stage_valid};
      e = exp_q.pop_front();
      compared++;
      if (got !== e) begin
        failed++;
        $display("FAIL halt_drain[%0d]: got %b required %b", i, got, e);
      end
    end
  endtask

  task automatic test_halt_squashed();
    stim_t st[9];
    logic [13:0] ex[9];
    logic [13:0] got, e;
    st = '{rst_i(nop_i()), nop_i(), alu_i(1), alu_i(2), alu_i(9), br_i(halt_i()), nop_i(), nop_i(), nop_i()};
    ex = '{exp_v(0, 0, 0, 0, 0, 0, 0, 0, 1, 'b000), nrm(0, 0, 'b000), nrm(0, 0, 'b000),
           nrm(0, 0, 'b001), nrm(0, 0, 'b011), exp_v(1, 1, 1, 1, 0, 0, 0, 0, 0, 'b111),
           nrm(0, 0, 'b110), nrm(0, 0, 'b100), nrm(0, 0, 'b000)};
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      apply(st[i]);
      exp_q.push_back(ex[i]);
      #3;
      got = {pc_en, ifid_en, ifid_flush, idex_bubble, ex_hold, mem_bubble, fwd_a, fwd_b, halted, stage_valid};
      e = exp_q.pop_front();
      compared++;
      if (got !== e) begin
        failed++;
        $display("FAIL halt_squashed[%0d]: got %b required %b", i, got, e);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    stim_t st[9];
    logic [13:0] ex[9];
    logic [13:0] got, e;
    st = '{mul_i(2), rst_i(use_i(2, 1, 0, 0, 8)), nop_i(), alu_i(1), alu_i(2), alu_i(9),
           halt_i(), rst_i(halt_i()), nop_i()};
    ex = '{nrm(0, 0, 'b000), exp_v(0, 0, 0, 0, 1, 1, 0, 0, 0, 'b001), nrm(0, 0, 'b000),
           nrm(0, 0, 'b000), nrm(0, 0, 'b001), nrm(0, 0, 'b011),
           exp_v(0, 0, 0, 1, 0, 0, 0, 0, 0, 'b111), exp_v(0, 0, 0, 1, 0, 0, 0, 0, 0, 'b110),
           nrm(0, 0, 'b000)};
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      apply(st[i]);
      exp_q.push_back(ex[i]);
      #3;
      got = {pc_en, ifid_en, ifid_flush, idex_bubble, ex_hold, mem_bubble, fwd_a, fwd_b, halted, stage_valid};
      e = exp_q.pop_front();
      compared++;
      if (got !== e) begin
        failed++;
        $display("FAIL reset_mid_op[%0d]: got %b required %b", i, got, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    apply(rst_i(nop_i()));
    repeat (2) @(posedge clk);
    test_reset();
    test_forwarding();
    test_load_use();
    test_multi_cycle();
    test_branch_over_load_use();
    test_halt_drain();
    test_halt_squashed();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
